// File: rtl/button_logic_array.sv
// Multi-channel button-to-LED logic: synchronise, debounce and edge-detect button pairs, drive LEDs by selectable function.
// Optional auto-repeat on held a-buttons is enabled by defining BUTTON_LOGIC_AUTO_REPEAT_EN.
module button_logic_array #(
    parameter int unsigned N_CH            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned REPEAT_CYCLES   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic [N_CH-1:0] btn_a,
    input  logic [N_CH-1:0] btn_b,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] a_press
);

    localparam int unsigned NB    = 2 * N_CH;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB-1:0]    RELEASED = ACTIVE_LOW ? {NB{1'b1}} : {NB{1'b0}};

    logic [NB-1:0]    raw;
    logic [NB-1:0]    s1;
    logic [NB-1:0]    s2;
    logic [NB-1:0]    p;
    logic [NB-1:0]    db;
    logic [NB-1:0]    db_prev;
    logic [NB-1:0]    press;
    logic [CNT_W-1:0] cnt [NB];

    logic [N_CH-1:0] db_a;
    logic [N_CH-1:0] press_a;
    logic [N_CH-1:0] press_b;
    logic [N_CH-1:0] rpt_evt;
    logic [N_CH-1:0] ev_a;
    logic [N_CH-1:0] tog;
    logic [N_CH-1:0] tog_nxt;

    // Bits [N_CH-1:0] are the a-buttons, [NB-1:N_CH] the b-buttons.
    assign raw     = {btn_b, btn_a};
    assign p       = s2 ^ RELEASED;
    assign press   = db & ~db_prev;
    assign db_a    = db[N_CH-1:0];
    assign press_a = press[N_CH-1:0];
    assign press_b = press[NB-1:N_CH];

    // Synchroniser and debounce for every raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= RELEASED;
            s2      <= RELEASED;
            db      <= '0;
            db_prev <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= raw;
            s2      <= s1;
            db_prev <= db;
            for (int unsigned i = 0; i < NB; i++) begin
                if (p[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= p[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef BUTTON_LOGIC_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt [N_CH];

    always_comb begin
        rpt_evt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            rpt_evt[i] = db_a[i] & ~press_a[i] & ~press_b[i] & (rpt_cnt[i] == RPT_LAST);
        end
    end

    // Repeat timer restarts on every press or repeat, and idles while released.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!db_a[i] || press_b[i] || press_a[i] || rpt_evt[i]) begin
                    rpt_cnt[i] <= '0;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
                end
            end
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^32'(REPEAT_CYCLES);
    assign rpt_evt           = '0;
`endif

    assign ev_a = press_a | rpt_evt;

    // b-press clears the latch and beats a simultaneous a-event.
    always_comb begin
        tog_nxt = tog;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (press_b[i]) begin
                tog_nxt[i] = 1'b0;
            end else if (ev_a[i]) begin
                tog_nxt[i] = ~tog[i];
            end
        end
    end

    // Toggle mode shows the post-update latch so led and a_press move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            tog     <= '0;
            led     <= '0;
            a_press <= '0;
        end else begin
            tog     <= tog_nxt;
            a_press <= ev_a;
            case (mode)
                2'b00:   led <= db_a & db[NB-1:N_CH];
                2'b01:   led <= db_a | db[NB-1:N_CH];
                2'b10:   led <= db_a ^ db[NB-1:N_CH];
                default: led <= tog_nxt;
            endcase
        end
    end

endmodule

// File: tb/tb_button_logic_array.sv
// Scoreboard bench for button_logic_array (N_CH=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, repeat disabled).
module tb_button_logic_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] btn_a;
    logic [1:0] btn_b;
    logic [1:0] led;
    logic [1:0] a_press;

    typedef struct {
        int         cyc;
        logic [1:0] led;
        logic [1:0] ap;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    button_logic_array #(
        .N_CH(2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1'b1),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .btn_a(btn_a),
        .btn_b(btn_b),
        .led(led),
        .a_press(a_press)
    );

    // Advance one edge and settle; inputs driven after this are captured at the next edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push_exp(input int c, input logic [1:0] l, input logic [1:0] a);
        exp_t e;
        e.cyc = c;
        e.led = l;
        e.ap  = a;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst   = 1'b1;
        mode  = 2'b00;
        btn_a = 2'b11;
        btn_b = 2'b11;
        step();
        step();
        checks += 2;
        if (led !== 2'b00) begin
            errors++;
            $display("FAIL reset_led got=%b exp=00", led);
        end
        if (a_press !== 2'b00) begin
            errors++;
            $display("FAIL reset_apress got=%b exp=00", a_press);
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) push_exp(cyc + k, 2'b00, 2'b00);
        repeat (20) begin
            step();
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks += 2;
                if (led !== e.led) begin
                    errors++;
                    $display("FAIL reset_idle_led cyc=%0d got=%b exp=%b", cyc, led, e.led);
                end
                if (a_press !== e.ap) begin
                    errors++;
                    $display("FAIL reset_idle_apress cyc=%0d got=%b exp=%b", cyc, a_press, e.ap);
                end
            end
        end
    endtask

    task automatic test_and();
        exp_t e;
        int   c0;
        mode = 2'b00;
        c0   = cyc;
        btn_a[0] = 1'b0;
        for (int k = 1; k <= 10; k++) push_exp(c0 + k, 2'b00, (k == 7) ? 2'b01 : 2'b00);
        c0 = c0 + 10;
        for (int k = 1; k <= 10; k++) push_exp(c0 + k, (k >= 7) ? 2'b01 : 2'b00, 2'b00);
        c0 = c0 + 10;
        for (int k = 1; k <= 12; k++) push_exp(c0 + k, (k >= 7) ? 2'b00 : 2'b01, 2'b00);
        for (int n = 0; n < 32; n++) begin
            if (n == 10) btn_b[0] = 1'b0;
            if (n == 20) begin
                btn_a[0] = 1'b1;
                btn_b[0] = 1'b1;
            end
            step();
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks += 2;
                if (led !== e.led) begin
                    errors++;
                    $display("FAIL and_led cyc=%0d got=%b exp=%b", cyc, led, e.led);
                end
                if (a_press !== e.ap) begin
                    errors++;
                    $display("FAIL and_apress cyc=%0d got=%b exp=%b", cyc, a_press, e.ap);
                end
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   c0;
        c0 = cyc;
        for (int k = 1; k <= 12; k++) push_exp(c0 + k, 2'b00, 2'b00);
        c0 = c0 + 12;
        for (int k = 1; k <= 14; k++) push_exp(c0 + k, 2'b00, (k == 7) ? 2'b10 : 2'b00);
        for (int n = 0; n < 26; n++) begin
            if (n == 0 || n == 12) btn_a[1] = 1'b0;
            if (n == 3 || n == 16) btn_a[1] = 1'b1;
            step();
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks += 2;
                if (led !== e.led) begin
                    errors++;
                    $display("FAIL glitch_led cyc=%0d got=%b exp=%b", cyc, led, e.led);
                end
                if (a_press !== e.ap) begin
                    errors++;
                    $display("FAIL glitch_apress cyc=%0d got=%b exp=%b", cyc, a_press, e.ap);
                end
            end
        end
    endtask

    // Channel 1 latch holds 1 from the accepted glitch-test press, so led[1]=1 in toggle mode.
    task automatic test_toggle();
        exp_t e;
        int   c0;
        c0 = cyc;
        mode = 2'b11;
        push_exp(c0 + 1, 2'b10, 2'b00);
        c0 = c0 + 1;
        for (int k = 1; k <= 20; k++) push_exp(c0 + k, (k >= 7) ? 2'b11 : 2'b10, (k == 7) ? 2'b01 : 2'b00);
        c0 = c0 + 20;
        for (int k = 1; k <= 20; k++) push_exp(c0 + k, (k >= 7) ? 2'b10 : 2'b11, (k == 7) ? 2'b01 : 2'b00);
        c0 = c0 + 20;
        for (int k = 1; k <= 20; k++) push_exp(c0 + k, (k >= 7) ? 2'b11 : 2'b10, (k == 7) ? 2'b01 : 2'b00);
        c0 = c0 + 20;
        for (int k = 1; k <= 20; k++) push_exp(c0 + k, (k >= 7) ? 2'b10 : 2'b11, (k == 7) ? 2'b01 : 2'b00);
        for (int n = 0; n < 81; n++) begin
            if (n == 1 || n == 21 || n == 41) btn_a[0] = 1'b0;
            if (n == 9 || n == 29 || n == 49) btn_a[0] = 1'b1;
            if (n == 61) begin
                btn_a[0] = 1'b0;
                btn_b[0] = 1'b0;
            end
            if (n == 69) begin
                btn_a[0] = 1'b1;
                btn_b[0] = 1'b1;
            end
            step();
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks += 2;
                if (led !== e.led) begin
                    errors++;
                    $display("FAIL toggle_led cyc=%0d got=%b exp=%b", cyc, led, e.led);
                end
                if (a_press !== e.ap) begin
                    errors++;
                    $display("FAIL toggle_apress cyc=%0d got=%b exp=%b", cyc, a_press, e.ap);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        exp_t       e;
        int         c0;
        logic [1:0] l;
        c0 = cyc;
        for (int k = 1; k <= 30; k++) begin
            if (k < 7)       l = 2'b00;
            else if (k < 11) l = 2'b01;
            else if (k < 14) l = 2'b00;
            else if (k < 17) l = 2'b01;
            else if (k < 19) l = 2'b11;
            else             l = 2'b00;
            push_exp(c0 + k, l, (k == 7) ? 2'b01 : 2'b00);
        end
        for (int n = 0; n < 30; n++) begin
            if (n == 0) begin
                mode     = 2'b10;
                btn_a[0] = 1'b0;
            end
            if (n == 10) mode = 2'b00;
            if (n == 13) mode = 2'b10;
            if (n == 16) mode = 2'b11;
            if (n == 18) begin
                mode     = 2'b00;
                btn_a[0] = 1'b1;
            end
            step();
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks += 2;
                if (led !== e.led) begin
                    errors++;
                    $display("FAIL mode_led cyc=%0d got=%b exp=%b", cyc, led, e.led);
                end
                if (a_press !== e.ap) begin
                    errors++;
                    $display("FAIL mode_apress cyc=%0d got=%b exp=%b", cyc, a_press, e.ap);
                end
            end
        end
    endtask

    // Reset covers edges 3 and 4 of the press; the first free edge acts as capture edge 0.
    task automatic test_reset_mid();
        exp_t e;
        int   c0;
        c0 = cyc;
        mode = 2'b00;
        for (int k = 1; k <= 16; k++) push_exp(c0 + k, 2'b00, (k == 11) ? 2'b01 : 2'b00);
        for (int n = 0; n < 30; n++) begin
            if (n == 0)  btn_a[0] = 1'b0;
            if (n == 2)  rst = 1'b1;
            if (n == 4)  rst = 1'b0;
            if (n == 16) btn_a[0] = 1'b1;
            step();
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks += 2;
                if (led !== e.led) begin
                    errors++;
                    $display("FAIL rstmid_led cyc=%0d got=%b exp=%b", cyc, led, e.led);
                end
                if (a_press !== e.ap) begin
                    errors++;
                    $display("FAIL rstmid_apress cyc=%0d got=%b exp=%b", cyc, a_press, e.ap);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_glitch();
        test_toggle();
        test_mode_switch();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
